// File: rtl/ex_wb_stage_if.sv
// ex_wb_stage_if: ID/EX operands in, EX/WB state and decode read port out.
// master = upstream pipeline and decode, slave = ex_wb_stage.
interface ex_wb_stage_if;
   logic       ID_EX_RegWrite;
   logic       ID_EX_ALUSrc;
   logic [7:0] ID_EX_Read_Data;
   logic [7:0] ID_EX_Imm_Data;
   logic [2:0] ID_EX_Read_Reg_Num;
   logic [2:0] ID_EX_Write_Reg_Num;
   logic [2:0] Read_Reg_Num;
   logic [7:0] Read_Data;
   logic       EX_WB_RegWrite;
   logic [7:0] EX_WB_Write_Data;
   logic [2:0] EX_WB_Write_Reg_Num;

   modport master (
      output ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Read_Data,
      output ID_EX_Imm_Data, ID_EX_Read_Reg_Num, ID_EX_Write_Reg_Num,
      output Read_Reg_Num,
      input  Read_Data, EX_WB_RegWrite, EX_WB_Write_Data,
      input  EX_WB_Write_Reg_Num
   );

   modport slave (
      input  ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Read_Data,
      input  ID_EX_Imm_Data, ID_EX_Read_Reg_Num, ID_EX_Write_Reg_Num,
      input  Read_Reg_Num,
      output Read_Data, EX_WB_RegWrite, EX_WB_Write_Data,
      output EX_WB_Write_Reg_Num
   );
endinterface

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: result select, EX/WB register and 8x8 register file.
// Define EX_WB_FWD_EN to add the EX/WB -> EX operand forwarding path.
module ex_wb_stage (
   input logic          Clk,
   input logic          Reset_n,
   ex_wb_stage_if.slave bus
);
   logic       r_wb_we;
   logic [7:0] r_wb_data;
   logic [2:0] r_wb_rd;
   logic [7:0] r_regs [8];

   logic       w_fwd_hit;
   logic       w_byp_hit;
   logic [7:0] w_operand;
   logic [7:0] w_result;

`ifdef EX_WB_FWD_EN
   assign w_fwd_hit = r_wb_we && (r_wb_rd == bus.ID_EX_Read_Reg_Num);
`else
   logic w_unused_rs;
   assign w_unused_rs = ^bus.ID_EX_Read_Reg_Num;
   assign w_fwd_hit   = 1'b0;
`endif

   assign w_operand = w_fwd_hit ? r_wb_data : bus.ID_EX_Read_Data;
   assign w_result  = bus.ID_EX_ALUSrc ? bus.ID_EX_Imm_Data : w_operand;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_wb_we   <= 1'b0;
         r_wb_data <= 8'h00;
         r_wb_rd   <= 3'd0;
      end else begin
         r_wb_we   <= bus.ID_EX_RegWrite;
         r_wb_data <= w_result;
         r_wb_rd   <= bus.ID_EX_Write_Reg_Num;
      end
   end

   // Each register resets to its own index.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int k = 0; k < 8; k++) begin
            r_regs[k] <= 8'(k);
         end
      end else if (r_wb_we) begin
         r_regs[r_wb_rd] <= r_wb_data;
      end
   end

   assign w_byp_hit = r_wb_we && (r_wb_rd == bus.Read_Reg_Num);

   assign bus.Read_Data = w_byp_hit ? r_wb_data
                                    : r_regs[bus.Read_Reg_Num];

   assign bus.EX_WB_RegWrite      = r_wb_we;
   assign bus.EX_WB_Write_Data    = r_wb_data;
   assign bus.EX_WB_Write_Reg_Num = r_wb_rd;
endmodule

// File: tb/tb_ex_wb_stage.sv
// tb_ex_wb_stage: directed steps with a scoreboard queue of expected values.
module tb_ex_wb_stage;
   logic Clk;
   logic Reset_n;

   ex_wb_stage_if u_if ();

   ex_wb_stage u_dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (u_if)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t q_exp[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic push(input string tag, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      q_exp.push_back(e);
   endtask

   task automatic chk(input logic [7:0] obs);
      exp_t e;
      n_cmp++;
      if (q_exp.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty observed=%h required=none", obs);
      end else begin
         e = q_exp.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic issue(input logic we, input logic src,
                        input logic [7:0] rdata, input logic [7:0] imm,
                        input logic [2:0] rs, input logic [2:0] rd);
      u_if.ID_EX_RegWrite      = we;
      u_if.ID_EX_ALUSrc        = src;
      u_if.ID_EX_Read_Data     = rdata;
      u_if.ID_EX_Imm_Data      = imm;
      u_if.ID_EX_Read_Reg_Num  = rs;
      u_if.ID_EX_Write_Reg_Num = rd;
   endtask

   task automatic bubble();
      issue(1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 3'd0);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] r,
                         input logic [7:0] val);
      push(tag, val);
      u_if.Read_Reg_Num = r;
      #1;
      chk(u_if.Read_Data);
   endtask

   task automatic wb_chk(input logic we, input logic [7:0] d,
                         input logic [2:0] rd);
      push("wb_we", {7'd0, we});
      push("wb_data", d);
      push("wb_rd", {5'd0, rd});
      #1;
      chk({7'd0, u_if.EX_WB_RegWrite});
      chk(u_if.EX_WB_Write_Data);
      chk({5'd0, u_if.EX_WB_Write_Reg_Num});
   endtask

   logic [7:0] fwd_exp;

   initial begin
`ifdef EX_WB_FWD_EN
      fwd_exp = 8'h3C;
`else
      fwd_exp = 8'h02;
`endif
      Reset_n = 1'b0;
      u_if.Read_Reg_Num = 3'd0;
      bubble();
      repeat (2) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      wb_chk(1'b0, 8'h00, 3'd0);
      for (int k = 0; k < 8; k++) begin
         rd_chk("reset_read", 3'(k), 8'(k));
      end

      // Immediate write with same-cycle bypass, then regfile commit
      issue(1'b1, 1'b1, 8'h00, 8'hA5, 3'd0, 3'd3);
      tick();
      wb_chk(1'b1, 8'hA5, 3'd3);
      rd_chk("bypass_r3", 3'd3, 8'hA5);
      bubble();
      tick();
      rd_chk("commit_r3", 3'd3, 8'hA5);

      // Dependent pair: forwarding decides r5
      issue(1'b1, 1'b1, 8'h00, 8'h3C, 3'd0, 3'd2);
      tick();
      issue(1'b1, 1'b0, 8'h02, 8'h00, 3'd2, 3'd5);
      tick();
      wb_chk(1'b1, fwd_exp, 3'd5);
      bubble();
      tick();
      rd_chk("fwd_r5", 3'd5, fwd_exp);
      rd_chk("commit_r2", 3'd2, 8'h3C);

      // Bubble carries data but commits/forwards nothing
      issue(1'b0, 1'b1, 8'h00, 8'hFF, 3'd0, 3'd1);
      tick();
      wb_chk(1'b0, 8'hFF, 3'd1);
      rd_chk("bubble_nobyp_r1", 3'd1, 8'h01);
      issue(1'b1, 1'b0, 8'h01, 8'h00, 3'd1, 3'd7);
      tick();
      wb_chk(1'b1, 8'h01, 3'd7);
      bubble();
      tick();
      rd_chk("bubble_nocommit_r1", 3'd1, 8'h01);
      rd_chk("commit_r7", 3'd7, 8'h01);

      // Back-to-back writes to r4
      issue(1'b1, 1'b1, 8'h00, 8'h11, 3'd0, 3'd4);
      tick();
      rd_chk("waw_first_r4", 3'd4, 8'h11);
      issue(1'b1, 1'b1, 8'h00, 8'h22, 3'd0, 3'd4);
      tick();
      rd_chk("waw_second_r4", 3'd4, 8'h22);
      bubble();
      tick();
      rd_chk("waw_final_r4", 3'd4, 8'h22);

      // Asynchronous reset mid-cycle with a write pending in WB
      issue(1'b1, 1'b1, 8'h00, 8'h77, 3'd0, 3'd6);
      tick();
      wb_chk(1'b1, 8'h77, 3'd6);
      bubble();
      #1;
      Reset_n = 1'b0;
      wb_chk(1'b0, 8'h00, 3'd0);
      @(posedge Clk);
      #3;
      Reset_n = 1'b1;
      rd_chk("reset_r6", 3'd6, 8'h06);
      rd_chk("reset_r3", 3'd3, 8'h03);
      rd_chk("reset_r4", 3'd4, 8'h04);

      if (q_exp.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover observed=%0d required=0",
                  q_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end
endmodule
